// File: rtl/interrupt_timer_if.sv
// rtl/interrupt_timer_if.sv - data-memory bus bundle between the CPU and the interrupt timer
interface interrupt_timer_if;
   logic        MemRd;
   logic        MemWr;
   logic [31:0] Addr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Hit;
   logic        IRQ;

   modport master (
      output MemRd, MemWr, Addr, WriteData,
      input  ReadData, Hit, IRQ
   );

   modport slave (
      input  MemRd, MemWr, Addr, WriteData,
      output ReadData, Hit, IRQ
   );
endinterface

// File: rtl/interrupt_timer.sv
// rtl/interrupt_timer.sv - memory-mapped 32-bit reload timer driving the CPU level interrupt
// TH at BASE_ADDR, TL at +4, TCON at +8; TCON = {status, irq enable, count enable}.
module interrupt_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic               clk,
   input  logic               reset,
   interrupt_timer_if.slave   bus
);

   localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
   localparam logic [29:0] BASE_W  = BASE_ADDR[31:2];

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic [2:0]  tcon_q, tcon_d;
   logic [15:0] pre_q, pre_d;
   logic        irq_q, irq_d;

   logic        hit_th, hit_tl, hit_tcon;
   logic        wr_th, wr_tl, wr_tcon;
   logic        tick, ovf;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^bus.Addr[1:0];

   always_comb begin
      hit_th   = (bus.Addr[31:2] == BASE_W);
      hit_tl   = (bus.Addr[31:2] == BASE_W + 30'd1);
      hit_tcon = (bus.Addr[31:2] == BASE_W + 30'd2);
      bus.Hit  = hit_th | hit_tl | hit_tcon;

      bus.ReadData = 32'd0;
      if (bus.MemRd) begin
         if (hit_th)   bus.ReadData = th_q;
         if (hit_tl)   bus.ReadData = tl_q;
         if (hit_tcon) bus.ReadData = {29'd0, tcon_q};
      end

      wr_th   = bus.MemWr & hit_th;
      wr_tl   = bus.MemWr & hit_tl;
      wr_tcon = bus.MemWr & hit_tcon;

      tick = tcon_q[0] && (pre_q == PRE_MAX);
      ovf  = tick && (tl_q == 32'hFFFF_FFFF);

      // Prescaler restarts from zero whenever counting is (or becomes) disabled.
      if (!tcon_q[0] || tick || (wr_tcon && !bus.WriteData[0]))
         pre_d = 16'd0;
      else
         pre_d = pre_q + 16'd1;

      th_d = wr_th ? bus.WriteData : th_q;

      // A software store to TL wins over both increment and reload.
      if (wr_tl)
         tl_d = bus.WriteData;
      else if (ovf)
         tl_d = th_q;
      else if (tick)
         tl_d = tl_q + 32'd1;
      else
         tl_d = tl_q;

      tcon_d = wr_tcon ? bus.WriteData[2:0] : tcon_q;
      // Hardware set beats a same-cycle software clear so no interrupt is lost.
      if (ovf && !wr_tl && tcon_q[1])
         tcon_d[2] = 1'b1;

      irq_d = tcon_q[1] & tcon_q[2];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         th_q   <= 32'd0;
         tl_q   <= 32'd0;
         tcon_q <= 3'd0;
         pre_q  <= 16'd0;
         irq_q  <= 1'b0;
      end else begin
         th_q   <= th_d;
         tl_q   <= tl_d;
         tcon_q <= tcon_d;
         pre_q  <= pre_d;
         irq_q  <= irq_d;
      end
   end

   assign bus.IRQ = irq_q;

endmodule

// File: doc/interrupt_timer.md
# interrupt_timer

Memory-mapped 32-bit reload timer that generates the level interrupt request consumed by the CPU controller's `IRQ` input. It sits on the data-memory bus beside the data RAM. The CPU programs it with the same `MemRd`/`MemWr` strobes the controller issues for `lw`/`sw`. It holds `IRQ` asserted until software clears the status bit from the handler. Masking while in supervisor mode is the controller's job, not this block's.

## Interface

**Parameters**
- `BASE_ADDR`, default 32'h4000_0000: byte address of TH. TL is at +4 and TCON at +8.
- `PRESCALE`, default 1: core clock cycles per count tick. Legal range 1..65535.

**Ports**
- `clk`, input, 1: sole clock. All state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `MemRd`, input, 1: bus read strobe.
- `MemWr`, input, 1: bus write strobe.
- `Addr`, input, 32: byte address. Bits [1:0] are ignored.
- `WriteData`, input, 32: store data.
- `ReadData`, output, 32: combinational load data. It is 0 unless `MemRd` is high and the address hits.
- `Hit`, output, 1: combinational. High when `Addr[31:2]` matches one of the three register words. Used by the bus read mux.
- `IRQ`, output, 1: registered. Equals `TCON[1] & TCON[2]`.

## Operation

**Registers**
- TH (offset 0), 32 bits, R/W: reload value.
- TL (offset 4), 32 bits, R/W: live counter.
- TCON (offset 8), 3 bits, R/W. Upper 29 bits read as 0 and are ignored on write.
  - [0] = count enable.
  - [1] = interrupt enable.
  - [2] = interrupt status.

**Prescaler**
- Internal counter `pre`, 16 bits.
- While TCON[0]=0, `pre` is held at 0.
- While TCON[0]=1, `pre` increments each cycle. When `pre == PRESCALE-1`, it wraps to 0 and asserts internal `tick` for that cycle.
- With PRESCALE=1, `tick` equals TCON[0].

**Counter**
- On `tick` with TL != 32'hFFFF_FFFF: TL <= TL+1 (32-bit, no carry out).
- On `tick` with TL == 32'hFFFF_FFFF (overflow):
  - TL <= TH, using the pre-edge value of TH.
  - If TCON[1]=1, TCON[2] <= 1.
  - If TCON[1]=0, TCON[2] is unchanged.

**Bus writes**
- A write takes effect when `MemWr` is high and the address hits.
- The register is updated at that edge.

**Simultaneous events, resolved in this order**
- CPU write to TL in the same cycle as a tick: the write wins. No increment and no reload that cycle. Overflow status is not set that cycle.
- CPU write to TH during an overflow reload: TL gets the old TH; TH gets the new value.
- CPU write to TCON during an overflow with TCON[1]=1:
  - TCON[1:0] take the written value.
  - TCON[2] <= WriteData[2] | 1, i.e. hardware set beats a software clear, so an interrupt is never lost.
- CPU write to TCON clearing bit 0:
  - Counting stops from that edge.
  - `pre` is forced to 0 at that edge.
  - A tick coincident with that write is still applied.
- `MemRd` and `MemWr` both high: the read returns pre-edge values and the write applies at the edge.

**Reset**
- At the edge with `reset` high: TH=0, TL=0, TCON=0, `pre`=0, `IRQ`=0.
- `ReadData` is 0 whenever `MemRd`=0.
- `reset` overrides every bus write and tick in that cycle.

## Timing

- **Reads:** zero latency. `ReadData` reflects register contents in the same cycle as `Addr`/`MemRd`, as required by the single-cycle `lw` path.
- **Writes:** one edge. The value is readable in the cycle after the store.
- **IRQ:** rises on the first edge after the overflow edge. It is registered from the post-edge TCON, so it is one cycle after status sets.
- **IRQ deassert:** one cycle after the edge at which software clears TCON[2] or TCON[1].
- **Overflow period:** with TL reloaded from TH, the next overflow occurs (2^32 - TH) × PRESCALE cycles after the reload edge.
- **Supervisor masking:** none here. `IRQ` stays high while the handler runs in supervisor mode; the controller ignores it there.

## Test plan

- **Reset:** assert `reset` 2 cycles mid-count (TCON=3, TL=5) → TH=TL=TCON=0, `IRQ`=0, and a read of TCON returns 0.
- **Basic reload/IRQ:** PRESCALE=1, TH=32'hFFFF_FFFC, TL=32'hFFFF_FFFC, TCON=3.
  - TL sequence FFFD, FFFE, FFFF, then FFFC.
  - TCON[2] sets at the wrap edge; `IRQ`=1 the following cycle.
  - Next overflow comes 4 cycles later.
- **Software clear vs. hardware set:** force overflow in the same cycle as a `sw` of 32'h3 to TCON → TCON reads 7 and `IRQ` stays 1. A later write of 3 with no overflow clears it (`IRQ`=0 one cycle later).
- **Prescaler:** PRESCALE=4, TL=0, TCON=1 → TL reads 1 after 4 cycles and 2 after 8.
  - Clear TCON[0] at cycle 9, re-enable at 12 → next increment comes 4 cycles after re-enable.
- **Masked overflow:** TCON=1 (interrupt enable off) with TL wrapping → TL reloads, TCON[2] stays 0, `IRQ` stays 0.
- **Bus decode:** read BASE_ADDR+12 and 32'h0000_0008 → `Hit`=0, `ReadData`=0.
  - Write TL in the same cycle as a tick → TL holds the written value next cycle (no +1).
  - `MemRd`=0 at a valid address → `ReadData`=0.
